// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bundle: pipeline status in, stall/bubble/flush controls and status out.
// The pipeline drives through master; the hazard control unit sits on slave.
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_muldiv_start;
  logic             muldiv_done;
  logic             ex_branch_taken;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             bubble_ex;
  logic             bubble_mem;
  logic             flush_id;
  logic             flush_ex;
  logic [1:0]       busy_state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_muldiv_start, muldiv_done, ex_branch_taken,
    input  stall_if, stall_id, stall_ex, bubble_ex, bubble_mem,
           flush_id, flush_ex, busy_state, stall_count
  );

  modport slave (
    input  ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_muldiv_start, muldiv_done, ex_branch_taken,
    output stall_if, stall_id, stall_ex, bubble_ex, bubble_mem,
           flush_id, flush_ex, busy_state, stall_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, multi-cycle mul/div stalls and
// post-branch flush windows, with a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic            clk,
  input logic            rst_n,
  hazard_control_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULDIV  = 2'd1,
    FLUSH   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [3:0]       FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       fcnt;
  logic [3:0]       fcnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;
  logic             s_if, s_id, s_ex, b_ex, b_mem, f_id, f_ex;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    s_if      = 1'b0;
    s_id      = 1'b0;
    s_ex      = 1'b0;
    b_ex      = 1'b0;
    b_mem     = 1'b0;
    f_id      = 1'b0;
    f_ex      = 1'b0;
    case (state)
      RUN: begin
        if (hz.ex_branch_taken) begin
          f_id = 1'b1;
          f_ex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FLUSH_RELOAD;
          end
        end else if (hz.ex_muldiv_start) begin
          // A unit that finishes in its first cycle never needs the pipeline held.
          if (!hz.muldiv_done) begin
            s_if      = 1'b1;
            s_id      = 1'b1;
            s_ex      = 1'b1;
            b_mem     = 1'b1;
            state_nxt = MULDIV;
          end
        end else if (load_use) begin
          s_if = 1'b1;
          s_id = 1'b1;
          b_ex = 1'b1;
        end
      end
      MULDIV: begin
        if (hz.muldiv_done) begin
          state_nxt = RUN;
        end else begin
          s_if  = 1'b1;
          s_id  = 1'b1;
          s_ex  = 1'b1;
          b_mem = 1'b1;
        end
      end
      FLUSH: begin
        f_id = 1'b1;
        // A fresh redirect restarts the squash window.
        if (hz.ex_branch_taken) begin
          f_ex     = 1'b1;
          fcnt_nxt = FLUSH_RELOAD;
          if (FLUSH_CYCLES <= 1) state_nxt = RUN;
        end else if (fcnt <= 4'd1) begin
          state_nxt = RUN;
          fcnt_nxt  = 4'd0;
        end else begin
          fcnt_nxt = fcnt - 4'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        fcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fcnt      <= 4'd0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (s_if) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Controls are forced low for the whole time reset is held.
  assign hz.stall_if    = rst_n & s_if;
  assign hz.stall_id    = rst_n & s_id;
  assign hz.stall_ex    = rst_n & s_ex;
  assign hz.bubble_ex   = rst_n & b_ex;
  assign hz.bubble_mem  = rst_n & b_mem;
  assign hz.flush_id    = rst_n & f_id;
  assign hz.flush_ex    = rst_n & f_ex;
  assign hz.busy_state  = state;
  assign hz.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (FLUSH_CYCLES 2/16-bit count,
// FLUSH_CYCLES 3/4-bit count) driven in lockstep and compared to a cycle model.
module tb_hazard_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(16)) hz_a ();
  hazard_control_unit_if #(.CNT_W(4))  hz_b ();

  hazard_control_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(hz_a.slave));
  hazard_control_unit #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .hz(hz_b.slave));

  int total = 0;
  int bad   = 0;

  logic       mr, u1, u2, ms, md, br;
  logic [4:0] rd, rs1, rs2;

  // Model: remaining flush cycles, mul/div in progress, stall count.
  int fl[2];
  bit imd[2];
  int sc[2];
  int fc[2]   = '{2, 3};
  int smax[2] = '{65535, 15};

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_MD    = 7'b1110100;
  localparam logic [6:0] O_LU    = 7'b1101000;
  localparam logic [6:0] O_FL2   = 7'b0000011;
  localparam logic [6:0] O_FL1   = 7'b0000010;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic a_mr, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                        input logic [4:0] a_rs2, input logic a_u1, input logic a_u2,
                        input logic a_ms, input logic a_md, input logic a_br);
    mr = a_mr; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; u1 = a_u1; u2 = a_u2;
    ms = a_ms; md = a_md; br = a_br;
  endtask

  task automatic apply();
    hz_a.ex_mem_read = mr; hz_a.ex_rd = rd; hz_a.id_rs1 = rs1; hz_a.id_rs2 = rs2;
    hz_a.id_uses_rs1 = u1; hz_a.id_uses_rs2 = u2; hz_a.ex_muldiv_start = ms;
    hz_a.muldiv_done = md; hz_a.ex_branch_taken = br;
    hz_b.ex_mem_read = mr; hz_b.ex_rd = rd; hz_b.id_rs1 = rs1; hz_b.id_rs2 = rs2;
    hz_b.id_uses_rs1 = u1; hz_b.id_uses_rs2 = u2; hz_b.ex_muldiv_start = ms;
    hz_b.muldiv_done = md; hz_b.ex_branch_taken = br;
  endtask

  function automatic logic [6:0] obs(input int k);
    if (k == 0)
      return {hz_a.stall_if, hz_a.stall_id, hz_a.stall_ex, hz_a.bubble_ex,
              hz_a.bubble_mem, hz_a.flush_id, hz_a.flush_ex};
    return {hz_b.stall_if, hz_b.stall_id, hz_b.stall_ex, hz_b.bubble_ex,
            hz_b.bubble_mem, hz_b.flush_id, hz_b.flush_ex};
  endfunction

  function automatic int obs_busy(input int k);
    return (k == 0) ? int'(hz_a.busy_state) : int'(hz_b.busy_state);
  endfunction

  function automatic int obs_cnt(input int k);
    return (k == 0) ? int'(hz_a.stall_count) : int'(hz_b.stall_count);
  endfunction

  task automatic model_eval(input int k, output logic [6:0] o, output int busy,
                            output int nfl, output bit nimd);
    bit lu;
    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    o = O_NONE; nfl = fl[k]; nimd = imd[k];
    busy = imd[k] ? 1 : (fl[k] > 0 ? 2 : 0);
    if (imd[k]) begin
      if (md) nimd = 0; else o = O_MD;
    end else if (fl[k] > 0) begin
      o = O_FL1;
      if (br) begin o = O_FL2; nfl = fc[k] - 1; end
      else nfl = fl[k] - 1;
    end else if (br) begin
      o = O_FL2; nfl = fc[k] - 1;
    end else if (ms) begin
      if (!md) begin o = O_MD; nimd = 1; end
    end else if (lu) begin
      o = O_LU;
    end
  endtask

  // One clock: apply inputs, compare both DUTs to the model (and to optional
  // hand-written constants), then advance the model across the rising edge.
  task automatic step(input string tag, input bit cst, input logic [6:0] wa, input int ba,
                      input logic [6:0] wb, input int bb);
    logic [6:0] o[2];
    int busy[2], nfl[2];
    bit nimd[2];
    apply();
    #1;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, o[k], busy[k], nfl[k], nimd[k]);
      check($sformatf("%s/ctl%0d", tag, k), 32'(obs(k)), 32'(o[k]));
      check($sformatf("%s/busy%0d", tag, k), obs_busy(k), busy[k]);
      check($sformatf("%s/cnt%0d", tag, k), obs_cnt(k), sc[k]);
    end
    if (cst) begin
      check($sformatf("%s/ctl_a", tag), 32'(obs(0)), 32'(wa));
      check($sformatf("%s/busy_a", tag), obs_busy(0), ba);
      check($sformatf("%s/ctl_b", tag), 32'(obs(1)), 32'(wb));
      check($sformatf("%s/busy_b", tag), obs_busy(1), bb);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (o[k][6] && sc[k] < smax[k]) sc[k]++;
      fl[k] = nfl[k];
      imd[k] = nimd[k];
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic [6:0] wa, input int ba,
                      input logic [6:0] wb, input int bb);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(tag, 1, wa, ba, wb, bb);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin fl[k] = 0; imd[k] = 0; sc[k] = 0; end
  endtask

  // Reset with every hazard input active; controls must still read zero.
  task automatic do_reset(input string tag);
    set_in(1, 5, 5, 5, 1, 1, 1, 0, 1);
    apply();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s/rctl%0d", tag, k), 32'(obs(k)), 32'(O_NONE));
      check($sformatf("%s/rbusy%0d", tag, k), obs_busy(k), 0);
      check($sformatf("%s/rcnt%0d", tag, k), obs_cnt(k), 0);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();
    model_clear();
    @(negedge clk);
    do_reset("init");

    // Load-use on rs2 for a single cycle.
    set_in(1, 5, 0, 5, 0, 1, 0, 0, 0);
    step("lu", 1, O_LU, 0, O_LU, 0);
    check("lu/cnt_a", obs_cnt(0), 1);
    idle("lu_after", O_NONE, 0, O_NONE, 0);
    set_in(1, 0, 0, 0, 1, 1, 0, 0, 0);
    step("lu_x0", 1, O_NONE, 0, O_NONE, 0);

    // Mul/div: start, three held cycles, done on the fourth following cycle.
    do_reset("md");
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("md0", 1, O_MD, 0, O_MD, 0);
    for (int i = 1; i < 4; i++) idle($sformatf("md%0d", i), O_MD, 1, O_MD, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("md_done", 1, O_NONE, 1, O_NONE, 1);
    idle("md_run", O_NONE, 0, O_NONE, 0);
    check("md/cnt_a", obs_cnt(0), 4);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("md_same", 1, O_NONE, 0, O_NONE, 0);

    // Branch collides with mul/div start and load-use; branch wins.
    set_in(1, 7, 7, 0, 1, 0, 1, 0, 1);
    step("br_pri", 1, O_FL2, 0, O_FL2, 0);
    idle("br_pri1", O_FL1, 2, O_FL1, 2);
    idle("br_pri2", O_NONE, 0, O_FL1, 2);
    idle("br_pri3", O_NONE, 0, O_NONE, 0);

    // Second redirect during the flush window reloads the counter.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("br2_0", 1, O_FL2, 0, O_FL2, 0);
    idle("br2_1", O_FL1, 2, O_FL1, 2);
    set_in(1, 3, 3, 0, 1, 0, 1, 1, 1);
    step("br2_2", 1, O_FL2, 0, O_FL2, 2);
    idle("br2_3", O_FL1, 2, O_FL1, 2);
    idle("br2_4", O_NONE, 0, O_FL1, 2);
    idle("br2_5", O_NONE, 0, O_NONE, 0);

    // Asynchronous reset in the middle of a mul/div stall.
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("mdr0", 1, O_MD, 0, O_MD, 0);
    idle("mdr1", O_MD, 1, O_MD, 1);
    set_in(1, 4, 4, 4, 1, 1, 1, 0, 1);
    apply();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mdr/ctl%0d", k), 32'(obs(k)), 32'(O_NONE));
      check($sformatf("mdr/busy%0d", k), obs_busy(k), 0);
      check($sformatf("mdr/cnt%0d", k), obs_cnt(k), 0);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle("mdr_run", O_NONE, 0, O_NONE, 0);

    // Long stall drives the 4-bit counter into saturation.
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("sat0", 1, O_MD, 0, O_MD, 0);
    for (int i = 1; i < 20; i++) idle($sformatf("sat%0d", i), O_MD, 1, O_MD, 1);
    check("sat/cnt_b", obs_cnt(1), 15);
    check("sat/cnt_a", obs_cnt(0), 20);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("sat_done", 1, O_NONE, 1, O_NONE, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0));
      step("rnd", 0, O_NONE, 0, O_NONE, 0);
      if (i == 300) do_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush_id is held after a taken branch (legal range 1-15).
REQ-002 Parameter CNT_W, default 16, width of stall_count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ex_mem_read  input  1  instruction in EX is a load.
REQ-006 ex_rd  input  5  destination register of the EX instruction.
REQ-007 id_rs1, id_rs2  input  5 each  source registers of the ID instruction.
REQ-008 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-009 ex_muldiv_start  input  1  EX holds a multi-cycle mul/div in its first EX cycle.
REQ-010 muldiv_done  input  1  mul/div result valid this cycle.
REQ-011 ex_branch_taken  input  1  EX resolves a taken branch or jump (redirect).
REQ-012 stall_if, stall_id, stall_ex  output  1 each  hold the PC / IF-ID / ID-EX registers.
REQ-013 bubble_ex, bubble_mem  output  1 each  insert a NOP into EX / MEM.
REQ-014 flush_id, flush_ex  output  1 each  squash the instruction in ID / EX.
REQ-015 busy_state  output  2  current FSM state (RUN=0, MULDIV=1, FLUSH=2).
REQ-016 stall_count  output  CNT_W  saturating count of cycles with stall_if=1.

Function
REQ-017 load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)), combinational.
REQ-018 Control outputs are combinational from state and current inputs; zero-latency; the state, flush counter and stall_count are registered.
REQ-019 RUN priority: ex_branch_taken > ex_muldiv_start > load_use.
REQ-020 RUN & ex_branch_taken: flush_id=1 and flush_ex=1 this cycle; next state FLUSH with counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in RUN.
REQ-021 RUN & ex_muldiv_start & !ex_branch_taken: stall_if=stall_id=stall_ex=1, bubble_mem=1; next state MULDIV, unless muldiv_done=1 in that same cycle, in which case all outputs are 0 and the state stays RUN.
REQ-022 RUN & load_use & no higher-priority event: stall_if=stall_id=1, bubble_ex=1 for that cycle only; the state stays RUN.
REQ-023 MULDIV & !muldiv_done: stall_if=stall_id=stall_ex=1, bubble_mem=1; the state is held.
REQ-024 MULDIV & muldiv_done: all control outputs are 0; next state RUN.
REQ-025 MULDIV ignores ex_branch_taken, ex_muldiv_start and load_use.
REQ-026 FLUSH: flush_id=1, all other control outputs are 0; the counter decrements each cycle; at counter=1 the next state is RUN.
REQ-027 FLUSH: load_use and ex_muldiv_start are ignored because the ID instruction is being squashed.
REQ-028 FLUSH & ex_branch_taken: flush_id=flush_ex=1; the counter reloads to FLUSH_CYCLES-1 (the newest redirect wins).
REQ-029 muldiv_done while in RUN or FLUSH is ignored.
REQ-030 stall_count increments by 1 on each clk edge where stall_if=1, saturates at 2^CNT_W-1 and never wraps.
REQ-031 Encoding 3 is illegal; from it the next state is RUN and all control outputs are 0.

Reset
REQ-032 While rst_n=0: state=RUN, flush counter=0, stall_count=0, and every control output is forced to 0 regardless of inputs.
REQ-033 Reset assertion mid-MULDIV or mid-FLUSH aborts immediately, with no further stall or flush cycles after rst_n deasserts.
REQ-034 After rst_n rises, the first rising clk edge evaluates in RUN.

Verification
REQ-035 ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> stall_if=stall_id=bubble_ex=1 for exactly that cycle; stall_count 0->1; ex_rd=0 variant -> no stall.
REQ-036 ex_muldiv_start pulse, muldiv_done on the 4th following cycle -> stall_if/id/ex and bubble_mem high for 4 cycles (including the start cycle), busy_state=1 throughout, then 0; stall_count=4.
REQ-037 ex_branch_taken pulse with FLUSH_CYCLES=2 -> cycle 0: flush_id=flush_ex=1; cycle 1: flush_id=1 only, busy_state=2; cycle 2: RUN, all outputs 0.
REQ-038 Same cycle ex_branch_taken=1, ex_muldiv_start=1, load_use true -> only flush_id/flush_ex asserted, no stalls, next state FLUSH.
REQ-039 Second branch during FLUSH, FLUSH_CYCLES=3 -> counter reloads, flush_id stays high 2 more cycles after the second branch.
REQ-040 rst_n pulled low during MULDIV -> outputs 0 asynchronously, stall_count=0, busy_state=0; stall_count preloaded near 2^CNT_W-1 saturates at max.
